mem_req_arbiter: RTL and testbench

MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

---
 rtl/sys_defs.sv | 28 ++
 rtl/mem_tag_owner_table.sv | 41 ++++
 rtl/mem_req_arbiter.sv | 116 +++++++++++
 tb/tb_mem_req_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_defs.sv
// Shared bus definitions for the memory request arbiter: command encoding,
// tag width and the owner-table entry layout. XLEN defaults to 32 if unset.
`ifndef XLEN
`define XLEN 32
`endif

package sys_defs;

    localparam int TAG_W    = 4;
    localparam int NUM_TAGS = 2 ** TAG_W;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } bus_command_t;

    typedef enum logic {
        OWNER_ICACHE = 1'b0,
        OWNER_DCACHE = 1'b1
    } owner_t;

    typedef struct packed {
        logic   valid;
        owner_t owner;
    } owner_entry_t;

endpackage

// File: rtl/mem_tag_owner_table.sv
// Tag -> requester ownership table: one entry per memory tag, written on an
// accepted load, cleared on the matching return, looked up combinationally.
module mem_tag_owner_table
    import sys_defs::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             write_en,
    input  logic [TAG_W-1:0] write_tag,
    input  owner_t           write_owner,
    input  logic             clear_en,
    input  logic [TAG_W-1:0] clear_tag,
    input  logic [TAG_W-1:0] lookup_tag,
    output owner_entry_t     lookup_entry,
    input  logic [TAG_W-1:0] probe_tag,
    output owner_entry_t     probe_entry
);

    owner_entry_t entries [NUM_TAGS];

    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: every entry is reset so outstanding tags are dropped; this keeps the table in flops rather than RAM.
            for (int i = 0; i < NUM_TAGS; i++) begin
                entries[i] <= '{valid: 1'b0, owner: OWNER_ICACHE};
            end
        end else begin
            if (clear_en) begin
                entries[clear_tag].valid <= 1'b0;
            end
            // Issued after the clear, so a same-tag re-accept keeps the new entry.
            if (write_en) begin
                entries[write_tag] <= '{valid: 1'b1, owner: write_owner};
            end
        end
    end

    assign lookup_entry = entries[lookup_tag];
    assign probe_entry  = entries[probe_tag];

endmodule

// File: rtl/mem_req_arbiter.sv
// Arbitrates icache/dcache requests onto a single memory port and routes
// accept/return tags back to the owner. Round-robin conflicts: ARB_ROUND_ROBIN_EN.
module mem_req_arbiter
    import sys_defs::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        icache2ctlr_command,
    input  logic [`XLEN-1:0]  icache2ctlr_addr,
    input  logic [1:0]        dcache2ctlr_command,
    input  logic [`XLEN-1:0]  dcache2ctlr_addr,
    input  logic [63:0]       dcache2ctlr_data,
    output logic [1:0]        proc2mem_command,
    output logic [`XLEN-1:0]  proc2mem_addr,
    output logic [63:0]       proc2mem_data,
    input  logic [TAG_W-1:0]  mem2proc_response,
    input  logic [63:0]       mem2proc_data,
    input  logic [TAG_W-1:0]  mem2proc_tag,
    output logic [TAG_W-1:0]  Ctlr2icache_response,
    output logic [63:0]       Ctlr2icache_data,
    output logic [TAG_W-1:0]  Ctlr2icache_tag,
    output logic [TAG_W-1:0]  Ctlr2proc_response,
    output logic [63:0]       Ctlr2proc_data,
    output logic [TAG_W-1:0]  Ctlr2proc_tag,
    output logic              route_err
);

    logic         icache_req;
    logic         dcache_req;
    logic         grant_icache;
    logic         grant_dcache;
    logic         accept;
    logic         table_write;
    logic         return_valid;
    logic         return_hit;
    logic         overwrite_err;
    owner_entry_t return_entry;
    owner_entry_t accept_entry;

    assign icache_req = (icache2ctlr_command != BUS_NONE);
    assign dcache_req = (dcache2ctlr_command != BUS_NONE);

`ifdef ARB_ROUND_ROBIN_EN
    owner_t last_grant;

    // Reset leaves icache as last grant, so dcache wins the first conflict.
    assign grant_dcache = dcache_req && (!icache_req || last_grant == OWNER_ICACHE);

    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant <= OWNER_ICACHE;
        end else if (accept) begin
            last_grant <= grant_dcache ? OWNER_DCACHE : OWNER_ICACHE;
        end
    end
`else
    assign grant_dcache = dcache_req;
`endif

    assign grant_icache = icache_req && !grant_dcache;
    assign accept       = (grant_icache || grant_dcache) && (mem2proc_response != '0);

    always_comb begin
        proc2mem_command = BUS_NONE;
        proc2mem_addr    = '0;
        proc2mem_data    = '0;
        if (grant_dcache) begin
            proc2mem_command = dcache2ctlr_command;
            proc2mem_addr    = dcache2ctlr_addr;
            proc2mem_data    = dcache2ctlr_data;
        end else if (grant_icache) begin
            proc2mem_command = icache2ctlr_command;
            proc2mem_addr    = icache2ctlr_addr;
        end
    end

    assign Ctlr2icache_response = (accept && grant_icache) ? mem2proc_response : '0;
    assign Ctlr2proc_response   = (accept && grant_dcache) ? mem2proc_response : '0;
    assign Ctlr2icache_data     = mem2proc_data;
    assign Ctlr2proc_data       = mem2proc_data;

    assign table_write = accept && (proc2mem_command == BUS_LOAD);

    mem_tag_owner_table u_owner_table (
        .clock        (clock),
        .reset        (reset),
        .write_en     (table_write),
        .write_tag    (mem2proc_response),
        .write_owner  (grant_dcache ? OWNER_DCACHE : OWNER_ICACHE),
        .clear_en     (return_hit),
        .clear_tag    (mem2proc_tag),
        .lookup_tag   (mem2proc_tag),
        .lookup_entry (return_entry),
        .probe_tag    (mem2proc_response),
        .probe_entry  (accept_entry)
    );

    assign return_valid = (mem2proc_tag != '0);
    assign return_hit   = return_valid && return_entry.valid;

    assign Ctlr2icache_tag = (return_hit && return_entry.owner == OWNER_ICACHE) ? mem2proc_tag : '0;
    assign Ctlr2proc_tag   = (return_hit && return_entry.owner == OWNER_DCACHE) ? mem2proc_tag : '0;

    // A tag returned in the same cycle is free again, so re-accepting it is legal.
    assign overwrite_err = table_write && accept_entry.valid
                        && !(return_hit && mem2proc_tag == mem2proc_response);

    always_ff @(posedge clock) begin
        if (reset) begin
            route_err <= 1'b0;
        end else if ((return_valid && !return_entry.valid) || overwrite_err) begin
            route_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed scoreboard bench for mem_req_arbiter; expected values follow the
// conflict policy selected by ARB_ROUND_ROBIN_EN.
module tb_mem_req_arbiter;
    import sys_defs::*;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [1:0]        icache2ctlr_command = '0;
    logic [`XLEN-1:0]  icache2ctlr_addr = '0;
    logic [1:0]        dcache2ctlr_command = '0;
    logic [`XLEN-1:0]  dcache2ctlr_addr = '0;
    logic [63:0]       dcache2ctlr_data = '0;
    logic [1:0]        proc2mem_command;
    logic [`XLEN-1:0]  proc2mem_addr;
    logic [63:0]       proc2mem_data;
    logic [TAG_W-1:0]  mem2proc_response = '0;
    logic [63:0]       mem2proc_data = '0;
    logic [TAG_W-1:0]  mem2proc_tag = '0;
    logic [TAG_W-1:0]  Ctlr2icache_response;
    logic [63:0]       Ctlr2icache_data;
    logic [TAG_W-1:0]  Ctlr2icache_tag;
    logic [TAG_W-1:0]  Ctlr2proc_response;
    logic [63:0]       Ctlr2proc_data;
    logic [TAG_W-1:0]  Ctlr2proc_tag;
    logic              route_err;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        string       name;
        logic [63:0] value;
    } exp_t;

    exp_t sb[$];

    mem_req_arbiter dut (
        .clock                (clock),
        .reset                (reset),
        .icache2ctlr_command  (icache2ctlr_command),
        .icache2ctlr_addr     (icache2ctlr_addr),
        .dcache2ctlr_command  (dcache2ctlr_command),
        .dcache2ctlr_addr     (dcache2ctlr_addr),
        .dcache2ctlr_data     (dcache2ctlr_data),
        .proc2mem_command     (proc2mem_command),
        .proc2mem_addr        (proc2mem_addr),
        .proc2mem_data        (proc2mem_data),
        .mem2proc_response    (mem2proc_response),
        .mem2proc_data        (mem2proc_data),
        .mem2proc_tag         (mem2proc_tag),
        .Ctlr2icache_response (Ctlr2icache_response),
        .Ctlr2icache_data     (Ctlr2icache_data),
        .Ctlr2icache_tag      (Ctlr2icache_tag),
        .Ctlr2proc_response   (Ctlr2proc_response),
        .Ctlr2proc_data       (Ctlr2proc_data),
        .Ctlr2proc_tag        (Ctlr2proc_tag),
        .route_err            (route_err)
    );

    always #5 clock = ~clock;

    function automatic logic [63:0] ret_data(input logic [TAG_W-1:0] tag);
        return 64'hA5A5_0000_0000_0000 | 64'(tag);
    endfunction

    task automatic push(input string name, input logic [63:0] value);
        sb.push_back('{name, value});
    endtask

    task automatic check(input logic [63:0] obs);
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard_empty: observed %0h required an expectation", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.value) else begin
                n_err++;
                $error("FAIL %s: observed %0h required %0h", e.name, obs, e.value);
            end
        end
    endtask

    // Drive one cycle of stimulus at the falling edge, settle for 1 ns.
    task automatic drive(input logic [1:0] icmd, input logic [31:0] iaddr,
                         input logic [1:0] dcmd, input logic [31:0] daddr,
                         input logic [63:0] ddata, input logic [TAG_W-1:0] resp,
                         input logic [TAG_W-1:0] rtag);
        @(negedge clock);
        icache2ctlr_command = icmd;
        icache2ctlr_addr    = `XLEN'(iaddr);
        dcache2ctlr_command = dcmd;
        dcache2ctlr_addr    = `XLEN'(daddr);
        dcache2ctlr_data    = ddata;
        mem2proc_response   = resp;
        mem2proc_tag        = rtag;
        mem2proc_data       = ret_data(rtag);
        #1;
    endtask

    task automatic expect_all(input logic [1:0] cmd, input logic [31:0] addr,
                              input logic [63:0] data, input logic [TAG_W-1:0] iresp,
                              input logic [TAG_W-1:0] dresp, input logic [TAG_W-1:0] itag,
                              input logic [TAG_W-1:0] dtag, input logic [TAG_W-1:0] rtag);
        push("proc2mem_command", 64'(cmd));
        push("proc2mem_addr", 64'(addr));
        push("proc2mem_data", data);
        push("icache_response", 64'(iresp));
        push("proc_response", 64'(dresp));
        push("icache_tag", 64'(itag));
        push("proc_tag", 64'(dtag));
        push("icache_data", ret_data(rtag));
        push("proc_data", ret_data(rtag));
        check(64'(proc2mem_command));
        check(64'(proc2mem_addr));
        check(proc2mem_data);
        check(64'(Ctlr2icache_response));
        check(64'(Ctlr2proc_response));
        check(64'(Ctlr2icache_tag));
        check(64'(Ctlr2proc_tag));
        check(Ctlr2icache_data);
        check(Ctlr2proc_data);
    endtask

    // Let the edge that samples the current inputs pass, then check the sticky flag.
    task automatic expect_err(input logic value);
        @(posedge clock);
        #1;
        push("route_err", 64'(value));
        check(64'(route_err));
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        icache2ctlr_command = BUS_NONE;
        dcache2ctlr_command = BUS_NONE;
        mem2proc_response   = '0;
        mem2proc_tag        = '0;
        mem2proc_data       = ret_data('0);
        #1;
        expect_all(BUS_NONE, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        reset = 1'b0;
        push("route_err_after_reset", 64'(0));
        check(64'(route_err));
    endtask

    logic [TAG_W-1:0] rr_i;
    logic [TAG_W-1:0] rr_d;

    initial begin
        do_reset();

        // Lone icache load accepted with tag 3, then returned.
        drive(BUS_LOAD, 32'h100, BUS_NONE, 0, 0, 4'd3, 4'd0);
        expect_all(BUS_LOAD, 32'h100, 0, 4'd3, 4'd0, 4'd0, 4'd0, 4'd0);
        drive(BUS_NONE, 0, BUS_NONE, 0, 0, 4'd0, 4'd3);
        expect_all(BUS_NONE, 0, 0, 4'd0, 4'd0, 4'd3, 4'd0, 4'd3);
        expect_err(1'b0);

        // Memory stalls three cycles, accepts on the fourth.
        for (int i = 0; i < 3; i++) begin
            drive(BUS_LOAD, 32'h500, BUS_NONE, 0, 0, 4'd0, 4'd0);
            expect_all(BUS_LOAD, 32'h500, 0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
        end
        drive(BUS_LOAD, 32'h500, BUS_NONE, 0, 0, 4'd9, 4'd0);
        expect_all(BUS_LOAD, 32'h500, 0, 4'd9, 4'd0, 4'd0, 4'd0, 4'd0);
        drive(BUS_NONE, 0, BUS_NONE, 0, 0, 4'd0, 4'd9);
        expect_all(BUS_NONE, 0, 0, 4'd0, 4'd0, 4'd9, 4'd0, 4'd9);
        expect_err(1'b0);

        // Three conflicting accepts: tags 5, 6, 8.
        drive(BUS_LOAD, 32'h200, BUS_LOAD, 32'h300, 0, 4'd5, 4'd0);
        expect_all(BUS_LOAD, 32'h300, 0, 4'd0, 4'd5, 4'd0, 4'd0, 4'd0);
        drive(BUS_LOAD, 32'h200, BUS_LOAD, 32'h300, 0, 4'd6, 4'd0);
`ifdef ARB_ROUND_ROBIN_EN
        expect_all(BUS_LOAD, 32'h200, 0, 4'd6, 4'd0, 4'd0, 4'd0, 4'd0);
        rr_i = 4'd6;
        rr_d = 4'd0;
`else
        expect_all(BUS_LOAD, 32'h300, 0, 4'd0, 4'd6, 4'd0, 4'd0, 4'd0);
        rr_i = 4'd0;
        rr_d = 4'd6;
`endif
        drive(BUS_LOAD, 32'h200, BUS_LOAD, 32'h300, 0, 4'd8, 4'd0);
        expect_all(BUS_LOAD, 32'h300, 0, 4'd0, 4'd8, 4'd0, 4'd0, 4'd0);
        drive(BUS_NONE, 0, BUS_NONE, 0, 0, 4'd0, 4'd5);
        expect_all(BUS_NONE, 0, 0, 4'd0, 4'd0, 4'd0, 4'd5, 4'd5);
        drive(BUS_NONE, 0, BUS_NONE, 0, 0, 4'd0, 4'd6);
        expect_all(BUS_NONE, 0, 0, 4'd0, 4'd0, rr_i, rr_d, 4'd6);
        drive(BUS_NONE, 0, BUS_NONE, 0, 0, 4'd0, 4'd8);
        expect_all(BUS_NONE, 0, 0, 4'd0, 4'd0, 4'd0, 4'd8, 4'd8);
        expect_err(1'b0);

        // Tag 4 returned to dcache and re-accepted for icache in one cycle.
        drive(BUS_NONE, 0, BUS_LOAD, 32'h600, 0, 4'd4, 4'd0);
        expect_all(BUS_LOAD, 32'h600, 0, 4'd0, 4'd4, 4'd0, 4'd0, 4'd0);
        drive(BUS_LOAD, 32'h700, BUS_NONE, 0, 0, 4'd4, 4'd4);
        expect_all(BUS_LOAD, 32'h700, 0, 4'd4, 4'd0, 4'd0, 4'd4, 4'd4);
        expect_err(1'b0);
        drive(BUS_NONE, 0, BUS_NONE, 0, 0, 4'd0, 4'd4);
        expect_all(BUS_NONE, 0, 0, 4'd0, 4'd0, 4'd4, 4'd0, 4'd4);
        expect_err(1'b0);

        // Independent return (tag 10) and accept (tag 12) in one cycle.
        drive(BUS_LOAD, 32'h800, BUS_NONE, 0, 0, 4'd10, 4'd0);
        expect_all(BUS_LOAD, 32'h800, 0, 4'd10, 4'd0, 4'd0, 4'd0, 4'd0);
        drive(BUS_NONE, 0, BUS_LOAD, 32'h900, 0, 4'd12, 4'd10);
        expect_all(BUS_LOAD, 32'h900, 0, 4'd0, 4'd12, 4'd10, 4'd0, 4'd10);
        drive(BUS_NONE, 0, BUS_NONE, 0, 0, 4'd0, 4'd12);
        expect_all(BUS_NONE, 0, 0, 4'd0, 4'd0, 4'd0, 4'd12, 4'd12);
        expect_err(1'b0);

        // Store is accepted but owns no tag; its "return" is a routing error.
        drive(BUS_NONE, 0, BUS_STORE, 32'h400, 64'hDEADBEEF, 4'd7, 4'd0);
        expect_all(BUS_STORE, 32'h400, 64'hDEADBEEF, 4'd0, 4'd7, 4'd0, 4'd0, 4'd0);
        expect_err(1'b0);
        drive(BUS_NONE, 0, BUS_NONE, 0, 0, 4'd0, 4'd7);
        expect_all(BUS_NONE, 0, 0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd7);
        expect_err(1'b1);

        // Reset drops outstanding tags 2 and 6.
        do_reset();
        drive(BUS_LOAD, 32'h110, BUS_NONE, 0, 0, 4'd2, 4'd0);
        expect_all(BUS_LOAD, 32'h110, 0, 4'd2, 4'd0, 4'd0, 4'd0, 4'd0);
        drive(BUS_NONE, 0, BUS_LOAD, 32'h120, 0, 4'd6, 4'd0);
        expect_all(BUS_LOAD, 32'h120, 0, 4'd0, 4'd6, 4'd0, 4'd0, 4'd0);
        do_reset();
        drive(BUS_NONE, 0, BUS_NONE, 0, 0, 4'd0, 4'd2);
        expect_all(BUS_NONE, 0, 0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd2);
        expect_err(1'b1);

        // Accept of a still-outstanding tag overwrites the owner and flags it.
        do_reset();
        drive(BUS_LOAD, 32'h130, BUS_NONE, 0, 0, 4'd13, 4'd0);
        expect_all(BUS_LOAD, 32'h130, 0, 4'd13, 4'd0, 4'd0, 4'd0, 4'd0);
        expect_err(1'b0);
        drive(BUS_NONE, 0, BUS_LOAD, 32'h140, 0, 4'd13, 4'd0);
        expect_all(BUS_LOAD, 32'h140, 0, 4'd0, 4'd13, 4'd0, 4'd0, 4'd0);
        expect_err(1'b1);
        drive(BUS_NONE, 0, BUS_NONE, 0, 0, 4'd0, 4'd13);
        expect_all(BUS_NONE, 0, 0, 4'd0, 4'd0, 4'd0, 4'd13, 4'd13);

        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_leftover: observed %0d entries required 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
